wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the pipeline: accepts retiring instructions from the execute stage through a one-entry valid/ready register, waits for the data-memory response on loads, aligns and sign-extends load data, and drives the write port of the decode-stage register file. It also exports a load-pending hazard indication for decode stall logic and a retired-instruction counter.

## Interface

- No parameters. Data width is fixed at 32 bits and register address width at 5 bits.

Ports:

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- x_valid  in  1  execute stage presents a retiring instruction
- x_ready  out  1  wb_stage accepts the instruction this cycle
- x_rd  in  5  destination register
- x_reg_we  in  1  instruction writes rd
- x_wb_sel  in  2  result source: 0 = ALU, 1 = PC+4, 2 = load, 3 = ALU
- x_alu_result  in  32  ALU result
- x_pc4  in  32  PC+4
- x_funct3  in  3  load width/sign
- x_addr_lo  in  2  load byte offset, address bits [1:0]
- dmem_resp_valid  in  1  data-memory read response valid, single-cycle pulse
- dmem_resp_data  in  32  raw word-aligned read data
- we  out  1  register-file write enable
- wb_addr  out  5  register-file write address
- wb_data  out  32  register-file write data
- load_pending  out  1  a load is waiting for its response
- pending_rd  out  5  rd of the waiting load; 0 when none is pending
- retire  out  1  one-cycle pulse per committed instruction
- instret  out  32  count of committed instructions
- resp_err  out  1  sticky flag: a response arrived while no load was waiting

## Operation

- State machine: EMPTY, FULL, WAIT.
- The execute stage hands over an instruction when x_valid and x_ready are both high.
- x_ready is high in EMPTY and FULL. It is low in WAIT.
- On accept:
  - If x_wb_sel is 2, go to WAIT. Latch rd, reg_we, funct3 and addr_lo.
  - Otherwise go to FULL. Latch rd, reg_we, and the selected data (ALU or PC+4).
- With no accept, FULL and EMPTY go to EMPTY.
- FULL is the commit cycle. FULL lasts exactly one cycle unless a new instruction is accepted in that same cycle, in which case the next state follows the accept rule above.
- In FULL:
  - retire = 1.
  - we = latched reg_we and (rd != 0).
  - wb_addr = rd and wb_data = latched data.
- In WAIT with dmem_resp_valid:
  - The aligned load value is latched.
  - The state goes to FULL.
  - x_ready stays 0 in this cycle.
- Load alignment, with lane = dmem_resp_data >> (8 × addr_lo):
  - funct3 000 (lb): sign-extend lane[7:0].
  - funct3 100 (lbu): zero-extend lane[7:0].
  - funct3 001 (lh): sign-extend lane[15:0]. addr_lo[0] is ignored (treated as 0).
  - funct3 101 (lhu): zero-extend lane[15:0]. addr_lo[0] is ignored.
  - funct3 010 (lw) and all other encodings: the full word; addr_lo is ignored.
- Outside FULL: we = 0, retire = 0, wb_addr = 0, wb_data = 0.
- load_pending = 1 exactly in WAIT, and pending_rd = the latched rd in WAIT.
  - Decode must stall any instruction whose rs1 or rs2 equals a nonzero pending_rd.
- instret increments by 1 on every retire. It wraps from 0xFFFFFFFF to 0.
- resp_err is set by a dmem_resp_valid received in EMPTY or FULL. That response is otherwise ignored. resp_err is cleared only by reset.
- rd = 0 with reg_we = 1: the instruction still retires and counts in instret, but we stays 0.

## Timing

- Reset: state EMPTY, pending load discarded.
- Reset values:
  - x_ready = 1
  - we = 0, wb_addr = 0, wb_data = 0
  - load_pending = 0, pending_rd = 0
  - retire = 0, instret = 0, resp_err = 0
- Reset overrides every other input in the same cycle.
- Non-load latency: accept on edge N → we/retire high during cycle N+1.
- Load latency: accept on edge N → WAIT from N+1. A response sampled on edge M → commit during cycle M+1.
  - The minimum is a response in cycle N+1, giving commit in N+2.
- Throughput is one non-load per cycle. Back-to-back accepts produce a FULL state on every consecutive cycle.
- Register-file writes are synchronous. The write is committed on the edge that ends the FULL cycle.
- A response that arrives in the same cycle as reset is ignored and does not set resp_err.

## Test plan

- **Non-load commit:** reset, then accept ALU op rd=5, data 0x1234 → next cycle we=1, wb_addr=5, wb_data=0x1234, retire=1, instret=1.
- **Load alignment:** load with funct3=000, addr_lo=3; response 0x80FF_0000 after 2 WAIT cycles → load_pending=1 and pending_rd=rd during WAIT, x_ready=0; then wb_data=0xFFFF_FF80. Repeat with funct3=101, addr_lo=2 → 0x0000_80FF.
- **Back-to-back with x0 target:** 4 back-to-back ALU ops, one with rd=0 → 4 consecutive retire pulses, we low only for the rd=0 op, instret=4.
- **Stray and simultaneous responses:**
  - A response in EMPTY sets resp_err=1 and causes no write.
  - A response in the same cycle as WAIT→FULL while x_valid=1 → the instruction is not accepted until the FULL cycle.
- **Reset mid-load:** reset asserted during WAIT → all outputs return to reset values and no write occurs. A response arriving in the cycle after reset sets resp_err.
- **Counter wrap:** instret forced near the top via 2^32 retires, or by a bench shortcut → count wraps from 0xFFFFFFFF to 0.

Source files
------------

// File: rtl/wb_stage_if.sv
// Execute-side handshake, data-memory response and register-file write port
// of the writeback stage, bundled for connection between stages.
interface wb_stage_if;
  logic        x_valid;
  logic        x_ready;
  logic [4:0]  x_rd;
  logic        x_reg_we;
  logic [1:0]  x_wb_sel;
  logic [31:0] x_alu_result;
  logic [31:0] x_pc4;
  logic [2:0]  x_funct3;
  logic [1:0]  x_addr_lo;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        load_pending;
  logic [4:0]  pending_rd;
  logic        retire;
  logic [31:0] instret;
  logic        resp_err;

  modport master (
    output x_valid, x_rd, x_reg_we, x_wb_sel, x_alu_result, x_pc4,
           x_funct3, x_addr_lo, dmem_resp_valid, dmem_resp_data,
    input  x_ready, we, wb_addr, wb_data, load_pending, pending_rd,
           retire, instret, resp_err
  );

  modport slave (
    input  x_valid, x_rd, x_reg_we, x_wb_sel, x_alu_result, x_pc4,
           x_funct3, x_addr_lo, dmem_resp_valid, dmem_resp_data,
    output x_ready, we, wb_addr, wb_data, load_pending, pending_rd,
           retire, instret, resp_err
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: one-entry holding register, load-response wait, load
// alignment, register-file write port, hazard export and retire counter.
//
// state | meaning
// EMPTY | no instruction held
// FULL  | commit cycle: register-file write and retire pulse
// WAIT  | load held, waiting for the data-memory response
module wb_stage (
  input logic     clk,
  input logic     reset,
  wb_stage_if.slave wb
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic [4:0]  rd_q;
  logic        reg_we_q;
  logic [31:0] data_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] instret_q;
  logic        resp_err_q;
  logic [31:0] lane_b, lane_h, load_val;

  assign accept = wb.x_valid && (state_q != WAIT);

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = EMPTY;
    if (accept)
      state_d = (wb.x_wb_sel == 2'd2) ? WAIT : FULL;
    else if (state_q == WAIT)
      state_d = wb.dmem_resp_valid ? FULL : WAIT;
  end

  always_comb begin
    wb.x_ready      = (state_q != WAIT);
    wb.retire       = (state_q == FULL);
    wb.we           = (state_q == FULL) && reg_we_q && (rd_q != 5'd0);
    wb.wb_addr      = (state_q == FULL) ? rd_q : 5'd0;
    wb.wb_data      = (state_q == FULL) ? data_q : 32'd0;
    wb.load_pending = (state_q == WAIT);
    wb.pending_rd   = (state_q == WAIT) ? rd_q : 5'd0;
    wb.instret      = instret_q;
    wb.resp_err     = resp_err_q;
  end

  // Halfword lanes ignore addr_lo[0]; misaligned halves are not split.
  always_comb begin
    lane_b = wb.dmem_resp_data >> {addr_lo_q, 3'b000};
    lane_h = wb.dmem_resp_data >> {addr_lo_q[1], 4'b0000};
    case (funct3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b[7:0]};
      3'b100:  load_val = {24'd0, lane_b[7:0]};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h[15:0]};
      3'b101:  load_val = {16'd0, lane_h[15:0]};
      default: load_val = wb.dmem_resp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= 5'd0;
      reg_we_q   <= 1'b0;
      data_q     <= 32'd0;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      instret_q  <= 32'd0;
      resp_err_q <= 1'b0;
    end else begin
      if (state_q == FULL)
        instret_q <= instret_q + 32'd1;
      if (wb.dmem_resp_valid && state_q != WAIT)
        resp_err_q <= 1'b1;
      if (state_q == WAIT && wb.dmem_resp_valid)
        data_q <= load_val;
      if (accept) begin
        rd_q      <= wb.x_rd;
        reg_we_q  <= wb.x_reg_we;
        funct3_q  <= wb.x_funct3;
        addr_lo_q <= wb.x_addr_lo;
        data_q    <= (wb.x_wb_sel == 2'd1) ? wb.x_pc4 : wb.x_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a transaction-level
// model of the held instruction, response handling and counters.
module tb_wb_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  wb_stage_if bus ();
  wb_stage dut (.clk(clk), .reset(reset), .wb(bus));

  always #5 clk = ~clk;

  // Model: what the stage is holding and what it has observed.
  bit          m_commit, m_wait, m_we, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_cnt;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  int          retire_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] r;
    int          ofs;
    ofs = int'(off);
    case (f3)
      3'd0, 3'd4: begin
        r = (w >> (8 * ofs)) % 32'd256;
        if (f3 == 3'd0 && r >= 32'd128) r = r - 32'd256;
      end
      3'd1, 3'd5: begin
        r = (w >> (16 * (ofs / 2))) % 32'd65536;
        if (f3 == 3'd1 && r >= 32'd32768) r = r - 32'd65536;
      end
      default: r = w;
    endcase
    return r;
  endfunction

  task automatic idle();
    reset = 1'b0;
    bus.x_valid = 1'b0; bus.x_rd = 5'd0; bus.x_reg_we = 1'b0; bus.x_wb_sel = 2'd0;
    bus.x_alu_result = 32'd0; bus.x_pc4 = 32'd0; bus.x_funct3 = 3'd0; bus.x_addr_lo = 2'd0;
    bus.dmem_resp_valid = 1'b0; bus.dmem_resp_data = 32'd0;
  endtask

  task automatic model_edge();
    bit nc, nw;
    if (reset) begin
      m_commit = 0; m_wait = 0; m_we = 0; m_err = 0; m_rd = 0; m_data = 0; m_cnt = 0;
      return;
    end
    if (m_commit) m_cnt = m_cnt + 1;
    nc = 0; nw = m_wait;
    if (m_wait && bus.dmem_resp_valid) begin
      m_data = ref_load(m_f3, m_off, bus.dmem_resp_data);
      nc = 1; nw = 0;
    end else if (bus.dmem_resp_valid) begin
      m_err = 1;
    end
    if (bus.x_valid && !m_wait) begin
      m_rd = bus.x_rd; m_we = bus.x_reg_we; m_f3 = bus.x_funct3; m_off = bus.x_addr_lo;
      if (bus.x_wb_sel == 2'd2) begin
        nw = 1; nc = 0;
      end else begin
        nc = 1; nw = 0;
        m_data = (bus.x_wb_sel == 2'd1) ? bus.x_pc4 : bus.x_alu_result;
      end
    end
    m_commit = nc; m_wait = nw;
  endtask

  task automatic check_all();
    chk("x_ready", 32'(bus.x_ready), 32'(!m_wait));
    chk("we", 32'(bus.we), 32'(m_commit && m_we && m_rd != 0));
    chk("wb_addr", 32'(bus.wb_addr), m_commit ? 32'(m_rd) : 32'd0);
    chk("wb_data", bus.wb_data, m_commit ? m_data : 32'd0);
    chk("load_pending", 32'(bus.load_pending), 32'(m_wait));
    chk("pending_rd", 32'(bus.pending_rd), m_wait ? 32'(m_rd) : 32'd0);
    chk("retire", 32'(bus.retire), 32'(m_commit));
    chk("instret", bus.instret, m_cnt);
    chk("resp_err", 32'(bus.resp_err), 32'(m_err));
    if (bus.retire) retire_seen++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic issue(input logic [4:0] rd, input bit rwe, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [2:0] f3, input logic [1:0] off);
    bus.x_valid = 1'b1; bus.x_rd = rd; bus.x_reg_we = rwe; bus.x_wb_sel = sel;
    bus.x_alu_result = alu; bus.x_pc4 = alu + 32'd4; bus.x_funct3 = f3; bus.x_addr_lo = off;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    tick();
    chk("rst_ready", 32'(bus.x_ready), 32'd1);

    // Non-load commit
    idle(); issue(5'd5, 1, 2'd0, 32'h1234, 3'd0, 2'd0); tick();
    chk("alu_we", 32'(bus.we), 32'd1);
    chk("alu_data", bus.wb_data, 32'h1234);
    idle(); tick();
    chk("alu_instret", bus.instret, 32'd1);

    // lb at offset 3, response after two WAIT cycles, with a new op offered alongside
    issue(5'd7, 1, 2'd2, 32'h0, 3'd0, 2'd3); tick();
    chk("lb_pend_rd", 32'(bus.pending_rd), 32'd7);
    idle(); tick();
    issue(5'd9, 1, 2'd0, 32'hABCD, 3'd0, 2'd0);
    bus.dmem_resp_valid = 1'b1; bus.dmem_resp_data = 32'h80FF_0000;
    chk("lb_ready_on_resp", 32'(bus.x_ready), 32'd0);
    tick();
    chk("lb_data", bus.wb_data, 32'hFFFF_FF80);
    bus.dmem_resp_valid = 1'b0; tick();
    chk("after_lb_data", bus.wb_data, 32'hABCD);

    // lhu at offset 2
    idle(); issue(5'd3, 1, 2'd2, 32'h0, 3'd5, 2'd2); tick();
    idle(); bus.dmem_resp_valid = 1'b1; bus.dmem_resp_data = 32'h80FF_0000; tick();
    chk("lhu_data", bus.wb_data, 32'h0000_80FF);
    idle(); tick();

    // Back-to-back with an x0 target
    retire_seen = 0;
    for (int i = 0; i < 4; i++) begin
      issue((i == 1) ? 5'd0 : 5'(i + 10), 1, 2'(i % 2), 32'(100 + i), 3'd0, 2'd0);
      tick();
      chk("b2b_we", 32'(bus.we), (i == 1) ? 32'd0 : 32'd1);
    end
    idle(); tick();
    chk("b2b_retires", 32'(retire_seen), 32'd4);

    // Stray response in EMPTY
    bus.dmem_resp_valid = 1'b1; bus.dmem_resp_data = 32'hDEAD_BEEF; tick();
    chk("stray_err", 32'(bus.resp_err), 32'd1);
    chk("stray_we", 32'(bus.we), 32'd0);

    // Reset mid-load, then a late response
    idle(); issue(5'd4, 1, 2'd2, 32'h0, 3'd2, 2'd0); tick();
    idle(); reset = 1'b1; bus.dmem_resp_valid = 1'b1; tick();
    chk("rst_err_clear", 32'(bus.resp_err), 32'd0);
    idle(); bus.dmem_resp_valid = 1'b1; tick();
    chk("late_resp_err", 32'(bus.resp_err), 32'd1);
    chk("late_resp_we", 32'(bus.we), 32'd0);

    // Counter wrap via direct preset of the counter
    idle(); tick();
    dut.instret_q = 32'hFFFF_FFFE; m_cnt = 32'hFFFF_FFFE;
    issue(5'd1, 1, 2'd0, 32'h1, 3'd0, 2'd0); tick(); tick();
    idle(); tick();
    chk("wrap", bus.instret, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) != 0)
        issue(5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom),
              $urandom, 3'($urandom), 2'($urandom));
      bus.dmem_resp_valid = ($urandom_range(0, 2) == 0);
      bus.dmem_resp_data  = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
